cbus_rr_arbiter: RTL

- N-port round-robin arbiter that shares the single CBus memory port (oreq/oresp to the RAM model) between cached/uncached requesters: the I-side and D-side CBus converters, plus spare ports for a future page-table walker or DMA.
- Grants one requester per transaction and holds the grant until the burst's last beat. It then rotates priority so no port starves.
- Replaces fixed-priority muxing in the top-level memory path.

---
 rtl/cbus_rr_arbiter_pkg.sv | 29 ++
 rtl/cbus_rr_arbiter_rr_pick.sv | 43 ++++
 rtl/cbus_rr_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/cbus_rr_arbiter_pkg.sv
// rtl/cbus_rr_arbiter_pkg.sv - CBus request/response types and arbiter state shared by the memory-port arbiter
package cbus_rr_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [63:0] data;
        logic [7:0]  strobe;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    // Round-robin successor of p among n ports.
    function automatic int unsigned ptr_wrap_inc(input int unsigned p, input int unsigned n);
        return (p + 32'd1 >= n) ? 32'd0 : p + 32'd1;
    endfunction

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// rtl/cbus_rr_arbiter_rr_pick.sv - first set request at or after a round-robin pointer (rotate, priority-encode, un-rotate)
module rr_pick #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = 1
) (
    input  logic [NUM_PORTS-1:0] req_vec_i,
    input  logic [PTR_W-1:0]     rr_ptr_i,
    output logic                 found_o,
    output logic [PTR_W-1:0]     idx_o
);

    logic [NUM_PORTS-1:0] rot;
    logic [PTR_W:0]       off;
    logic [PTR_W:0]       sum;

    always_comb begin
        rot     = '0;
        off     = '0;
        sum     = '0;
        found_o = 1'b0;
        idx_o   = '0;
        // rot[k] is the request k positions after the pointer.
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum = {1'b0, rr_ptr_i} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_PORTS)) begin
                sum = sum - (PTR_W+1)'(NUM_PORTS);
            end
            rot[k] = req_vec_i[sum[PTR_W-1:0]];
        end
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found_o = 1'b1;
                off     = (PTR_W+1)'(k);
            end
        end
        sum = {1'b0, rr_ptr_i} + off;
        if (sum >= (PTR_W+1)'(NUM_PORTS)) begin
            sum = sum - (PTR_W+1)'(NUM_PORTS);
        end
        idx_o = sum[PTR_W-1:0];
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// rtl/cbus_rr_arbiter.sv - round-robin arbiter sharing one CBus memory port among NUM_PORTS requesters
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  cbus_req_t  [NUM_PORTS-1:0]  ireqs,
    output cbus_resp_t [NUM_PORTS-1:0]  iresps,
    output cbus_req_t                   oreq,
    input  cbus_resp_t                  oresp,
    output logic       [NUM_PORTS-1:0]  grant,
    output logic                        busy
);

    arb_state_t           state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     sel_q, sel_d;
    logic [NUM_PORTS-1:0] req_vec;
    logic                 pick_found;
    logic [PTR_W-1:0]     pick_idx;

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_vec[i] = ireqs[i].valid;
        end
    end

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_rr_pick (
        .req_vec_i (req_vec),
        .rr_ptr_i  (rr_ptr_q),
        .found_o   (pick_found),
        .idx_o     (pick_idx)
    );

    // The pick is only registered in IDLE, so oreq never depends on ireqs.valid in the same idle cycle.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        oreq     = '0;
        iresps   = '0;
        grant    = '0;
        busy     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                oreq          = ireqs[sel_q];
                iresps[sel_q] = oresp;
                grant[sel_q]  = 1'b1;
                busy          = 1'b1;
                // Owner dropping valid is treated like completion so a flushed port cannot wedge the bus.
                if (!ireqs[sel_q].valid || (oresp.ready && oresp.last)) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = PTR_W'(ptr_wrap_inc(32'(sel_q), NUM_PORTS));
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
        end
    end

endmodule
